// File: rtl/sdram_pkg.sv
// Shared definitions for the W9825G6KH front-end and controller: address layout,
// refresh/timing constants and SDRAM command encodings.
package sdram_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;

  localparam int unsigned BA_W  = 2;
  localparam int unsigned ROW_W = 13;
  localparam int unsigned COL_W = 9;

  localparam int unsigned COL_LSB = 0;
  localparam int unsigned ROW_LSB = COL_LSB + COL_W;
  localparam int unsigned BA_LSB  = ROW_LSB + ROW_W;

  localparam int unsigned REQ_W = 1 + ADDR_W + DATA_W;

  // 7.8us refresh period at 166MHz is 1300 cycles; 1250 leaves margin.
  localparam int unsigned REFRESH_INTERVAL_CYC = 1250;
  localparam int unsigned MAX_REFRESH_DEBT     = 8;

  localparam int unsigned T_RP_CYC   = 3;
  localparam int unsigned T_RCD_CYC  = 3;
  localparam int unsigned T_RFC_CYC  = 10;
  localparam int unsigned T_MRD_CYC  = 2;
  localparam int unsigned CAS_LAT    = 3;
  localparam int unsigned T_INIT_CYC = 33334;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_MRS       = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_BST       = 4'b0110,
    CMD_NOP       = 4'b0111,
    CMD_DESEL     = 4'b1111
  } sdram_cmd_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [BA_W-1:0]  ba;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } addr_split_t;

  function automatic addr_split_t split_addr(input logic [ADDR_W-1:0] addr);
    addr_split_t s;
    s.ba  = addr[BA_LSB  +: BA_W];
    s.row = addr[ROW_LSB +: ROW_W];
    s.col = addr[COL_LSB +: COL_W];
    return s;
  endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit to tell full from empty.
module sdram_req_fifo
  import sdram_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = REQ_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/sdram_request_scheduler.sv
// Host-side front-end of the SDRAM controller: request FIFO, refresh timer/debt and
// a single registered command slot arbitrating refresh over host traffic.
module sdram_request_scheduler
  import sdram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned REFRESH_INTERVAL = REFRESH_INTERVAL_CYC,
  parameter int unsigned MAX_DEBT         = MAX_REFRESH_DEBT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_ready,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_refresh,
  output logic              cmd_we,
  output logic [BA_W-1:0]   cmd_ba,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [COL_W-1:0]  cmd_col,
  output logic [DATA_W-1:0] cmd_wdata,
  output logic              refresh_ovf
);

  localparam logic [0:0] S_WAIT_INIT = 1'b0;
  localparam logic [0:0] S_RUN       = 1'b1;

  localparam int unsigned TW = $clog2(REFRESH_INTERVAL);
  localparam int unsigned DW = $clog2(MAX_DEBT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_INTERVAL - 1);
  localparam logic [DW-1:0] DEBT_MAX   = DW'(MAX_DEBT);

  logic [0:0]        r_state;
  logic [TW-1:0]     r_timer;
  logic [DW-1:0]     r_debt;
  logic              r_ovf;

  logic              r_cmd_valid;
  logic              r_cmd_refresh;
  logic              r_cmd_we;
  logic [BA_W-1:0]   r_cmd_ba;
  logic [ROW_W-1:0]  r_cmd_row;
  logic [COL_W-1:0]  r_cmd_col;
  logic [DATA_W-1:0] r_cmd_wdata;

  logic              w_in_run;
  logic              w_run;
  logic              w_leave;
  logic              w_tick;
  logic              w_load;
  logic              w_issue_ref;
  logic              w_req_fire;
  logic              w_bypass;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_have_req;
  req_t              w_req_in;
  req_t              w_fifo_dout;
  req_t              w_next_req;
  addr_split_t       w_split;

  assign w_in_run   = (r_state == S_RUN);
  assign w_run      = w_in_run & ctrl_ready;
  assign w_leave    = w_in_run & ~ctrl_ready;
  assign req_ready  = w_in_run & ~w_fifo_full;
  assign w_req_fire = req_valid & req_ready;

  assign w_tick      = w_run & (r_timer == TIMER_LAST);
  assign w_load      = w_run & (~r_cmd_valid | cmd_ready);
  assign w_issue_ref = w_load & (r_debt != '0);

  // An empty FIFO lets the incoming request go straight into the slot, giving
  // one-cycle latency without breaking order (nothing older is queued).
  assign w_bypass    = w_load & (r_debt == '0) & w_fifo_empty & w_req_fire;
  assign w_fifo_pop  = w_load & (r_debt == '0) & ~w_fifo_empty;
  assign w_fifo_push = w_run & w_req_fire & ~w_bypass;
  assign w_have_req  = ~w_fifo_empty | w_bypass;

  always_comb begin
    w_req_in       = '0;
    w_req_in.we    = req_we;
    w_req_in.addr  = req_addr;
    w_req_in.wdata = req_wdata;
  end

  assign w_next_req = w_fifo_empty ? w_req_in : w_fifo_dout;
  assign w_split    = split_addr(w_next_req.addr);

  sdram_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_leave),
    .i_push  (w_fifo_push),
    .i_data  (w_req_in),
    .i_pop   (w_fifo_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT_INIT;
    end else begin
      case (r_state)
        S_WAIT_INIT: if (ctrl_ready)  r_state <= S_RUN;
        default:     if (!ctrl_ready) r_state <= S_WAIT_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_leave) begin
      r_timer <= '0;
    end else if (w_run) begin
      r_timer <= w_tick ? '0 : r_timer + TW'(1);
    end
  end

  // A tick coinciding with a refresh issue nets to zero and never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_debt <= '0;
      r_ovf  <= 1'b0;
    end else if (w_leave) begin
      r_debt <= '0;
    end else begin
      case ({w_tick, w_issue_ref})
        2'b10: begin
          if (r_debt == DEBT_MAX) r_ovf <= 1'b1;
          else                    r_debt <= r_debt + DW'(1);
        end
        2'b01:   r_debt <= r_debt - DW'(1);
        default: r_debt <= r_debt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid   <= 1'b0;
      r_cmd_refresh <= 1'b0;
      r_cmd_we      <= 1'b0;
      r_cmd_ba      <= '0;
      r_cmd_row     <= '0;
      r_cmd_col     <= '0;
      r_cmd_wdata   <= '0;
    end else if (w_leave || (w_load && !w_issue_ref && !w_have_req)) begin
      r_cmd_valid   <= 1'b0;
      r_cmd_refresh <= 1'b0;
      r_cmd_we      <= 1'b0;
      r_cmd_ba      <= '0;
      r_cmd_row     <= '0;
      r_cmd_col     <= '0;
      r_cmd_wdata   <= '0;
    end else if (w_issue_ref) begin
      r_cmd_valid   <= 1'b1;
      r_cmd_refresh <= 1'b1;
      r_cmd_we      <= 1'b0;
      r_cmd_ba      <= '0;
      r_cmd_row     <= '0;
      r_cmd_col     <= '0;
      r_cmd_wdata   <= '0;
    end else if (w_load) begin
      r_cmd_valid   <= 1'b1;
      r_cmd_refresh <= 1'b0;
      r_cmd_we      <= w_next_req.we;
      r_cmd_ba      <= w_split.ba;
      r_cmd_row     <= w_split.row;
      r_cmd_col     <= w_split.col;
      r_cmd_wdata   <= w_next_req.wdata;
    end
  end

  assign cmd_valid   = r_cmd_valid;
  assign cmd_refresh = r_cmd_refresh;
  assign cmd_we      = r_cmd_we;
  assign cmd_ba      = r_cmd_ba;
  assign cmd_row     = r_cmd_row;
  assign cmd_col     = r_cmd_col;
  assign cmd_wdata   = r_cmd_wdata;
  assign refresh_ovf = r_ovf;

endmodule
